// File: rtl/spi_mult_pkg.sv
// Shared encodings for the SPI multiplier peripheral: shift-register modes
// and the transaction sequencer state set.
package spi_mult_pkg;

  typedef enum logic [1:0] {
    SR_HOLD      = 2'b00,
    SR_SHIFT_IN  = 2'b01,
    SR_LOAD      = 2'b10,
    SR_SHIFT_OUT = 2'b11
  } sr_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    WAIT,
    LOAD,
    SEND,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter shared by the receive and transmit phases; tc flags the
// increment that brings the count to DATA_W.
module spi_bit_counter #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign tc = inc && (count == LAST);

endmodule

// File: rtl/spi_mult_sequencer.sv
// One CS-low frame = receive operand, run multiplier, load product, shift out.
// Abortable by CS rising in any state; WAIT is guarded by a timeout.
module spi_mult_sequencer
  import spi_mult_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sclk_pos,
  input  logic       sclk_neg,
  input  logic       mult_done,
  output logic [1:0] sr_mode,
  output logic       mult_start,
  output logic       miso_en,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  sr_mode_t      mode;
  logic          bit_clr, bit_inc, bit_tc;
  logic [TW-1:0] tcnt;
  logic          to_last;

  // Strobes only count while CS is still low; an abort cycle issues nothing.
  assign bit_inc = !cs && ((state == RECV && sclk_pos) || (state == SEND && sclk_neg));
  assign bit_clr = (state == IDLE && !cs) || (state == LOAD);
  assign to_last = (tcnt == TO_LAST);

  spi_bit_counter #(.DATA_W(DATA_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bit_clr),
    .inc   (bit_inc),
    .tc    (bit_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (state != IDLE && cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!cs) state_nxt = RECV;
        RECV:    if (bit_tc) state_nxt = START;
        START:   state_nxt = WAIT;
        WAIT:    if (mult_done) state_nxt = LOAD;
                 else if (to_last) state_nxt = ERR;
        LOAD:    state_nxt = SEND;
        SEND:    if (bit_tc) state_nxt = FIN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    mode       = SR_HOLD;
    mult_start = 1'b0;
    miso_en    = 1'b0;
    case (state)
      RECV:  if (sclk_pos && !cs) mode = SR_SHIFT_IN;
      START: mult_start = !cs;
      LOAD:  if (!cs) mode = SR_LOAD;
      SEND: begin
        miso_en = 1'b1;
        if (sclk_neg && !cs) mode = SR_SHIFT_OUT;
      end
      default: ;
    endcase
  end

  assign sr_mode = mode;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt <= '0;
    else if (state == START) tcnt <= '0;
    else if (state == WAIT)  tcnt <= tcnt + 1'b1;
  end

  // Sticky until the next frame begins, so the host can read it after CS rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err <= 1'b0;
    else if (state == IDLE && !cs)           err <= 1'b0;
    else if (state == WAIT && state_nxt == ERR) err <= 1'b1;
  end

endmodule

// File: doc/spi_mult_sequencer.md
# spi_mult_sequencer

Transaction sequencer for the SPI multiplier peripheral: it drives the peripheral's shift register, multiplier and MISO gating from conditioned SPI strobes. One CS-low frame carries one multiply: receive an operand byte, run the multiplier, load the product, shift it out. It sits between the three input conditioners and the shift-register/multiplier datapath, replacing ad-hoc sequencing with a single, abortable, timeout-guarded FSM.

## Interface
- DATA_W, 8, frame width in bits; operand byte is {B[7:4], A[3:0]}, product is DATA_W bits
- TIMEOUT, 16, max clk cycles spent in WAIT for mult_done before error
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cs  in  1  conditioned chip select, active low
- sclk_pos  in  1  one-cycle strobe, conditioned SCLK rising edge
- sclk_neg  in  1  one-cycle strobe, conditioned SCLK falling edge
- mult_done  in  1  multiplier result valid (level)
- sr_mode  out  2  shift-register mode: 00 HOLD, 01 SHIFT_IN, 10 LOAD, 11 SHIFT_OUT
- mult_start  out  1  one-cycle start pulse to multiplier
- miso_en  out  1  MISO buffer enable
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag, cleared on next CS falling edge

## Operation
- States: IDLE, RECV, START, WAIT, LOAD, SEND, FIN, ERR.
- IDLE: on cs==0 -> RECV, bit counter cleared, err cleared.
- RECV: each sclk_pos asserts sr_mode=SHIFT_IN that cycle and increments counter; on the DATA_W-th strobe -> START.
- START: mult_start=1 for exactly one cycle; timeout counter cleared -> WAIT.
- WAIT: mult_done=1 -> LOAD; timeout counter reaches TIMEOUT-1 without done -> ERR (err set).
- LOAD: sr_mode=LOAD for exactly one cycle; bit counter cleared -> SEND.
- SEND: miso_en=1; each sclk_neg asserts sr_mode=SHIFT_OUT that cycle and increments counter; after DATA_W strobes -> FIN.
- FIN / ERR: miso_en=0, sr_mode=HOLD; wait for cs==1 -> IDLE.
- sr_mode is HOLD in every cycle not listed above.
- SCLK strobes in START, WAIT, LOAD, FIN, ERR are ignored; the master must allow turnaround before clocking out.
- cs==1 in any non-IDLE state -> IDLE next cycle (abort); takes priority over any simultaneous sclk strobe or mult_done; no mult_start, LOAD or SHIFT issued that cycle.
- Counters saturate-free: bit counter width clog2(DATA_W)+1, timeout counter width clog2(TIMEOUT)+1; both only reset or increment as stated.

## Timing
- Reset: state IDLE, counters 0, sr_mode=00, mult_start=0, miso_en=0, busy=0, err=0.
- sr_mode during RECV/SEND is a same-cycle decode of state and strobe (Mealy); all other outputs are registered or state-decoded (Moore).
- mult_start rises the cycle after the DATA_W-th sclk_pos.
- Earliest LOAD: 1 cycle after mult_done seen in WAIT; miso_en rises the cycle after LOAD.
- Minimum frame core latency: 8th sclk_pos -> START (1) -> WAIT (>=1) -> LOAD (1) -> SEND.
- mult_done already high on WAIT entry -> LOAD next cycle (stale done is the datapath's responsibility).

## Structure
- Package spi_mult_pkg: sr_mode encodings (SR_HOLD, SR_SHIFT_IN, SR_LOAD, SR_SHIFT_OUT) and the state enum; shared with the shift register.
- One sub-module: spi_bit_counter (clear, inc, terminal count at DATA_W), reused for RECV and SEND.

## Test plan
- Full frame, operand 0x32, done 3 cycles after start -> 8 SHIFT_IN pulses, one mult_start, one LOAD, 8 SHIFT_OUT pulses, miso_en high only in SEND, back to IDLE after cs rises.
- mult_done never asserted, TIMEOUT=16 -> ERR after 16 WAIT cycles, err=1, miso_en=0; err clears on next cs fall.
- cs rises after 5 sclk_pos -> IDLE next cycle, no mult_start; following frame completes normally.
- cs rise coincident with 8th sclk_pos -> no SHIFT_IN that cycle, no mult_start, state IDLE.
- sclk_neg strobes during WAIT -> no SHIFT_OUT issued; SEND still emits exactly 8 SHIFT_OUT.
- rst_n asserted mid-SEND -> all outputs reset values immediately (asynchronous), state IDLE.
